seq_detect: RTL and testbench

SEQ_DETECT -- requirements
Module: seq_detect

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_detect_sat_counter.sv | 35 +++
 rtl/seq_detect.sv | 101 ++++++++++
 tb/tb_seq_detect.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_detect_pkg;

  // Largest supported pattern length; also sizes the fill counter.
  localparam int PAT_W_MAX = 16;

  // Detector control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step on inc unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector with Mealy match flag and optional match counter.
// Define SEQ_DETECT_CNT_EN to build the saturating match counter; without it
// match_cnt is tied to zero and no counter registers exist.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             en,
  input  logic             x,
  output logic             y,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  // Fill counter is sized for the largest pattern so widths stay fixed.
  localparam int FILL_W = $clog2(PAT_W_MAX + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-2:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              armed_q, armed_d;

  // Candidate window: stored history followed by the current serial bit.
  logic [PAT_W-1:0]  cand;
  assign cand = {hist_q, x};

  // Mealy match: only when armed, bit valid and no load overriding it.
  assign y = (state_q == ARMED) && en && !load && (cand == pat_q);

  // Next-state logic: load dominates, then serial bit acceptance.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (load) begin
      state_d = FILL;
      pat_d   = pattern_in;
      hist_d  = '0;
      fill_d  = '0;
    end else if (en && (state_q != IDLE)) begin
      hist_d = cand[PAT_W-2:0];
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_ONE;
      end
      if ((state_q == FILL) && (fill_d >= FILL_ARM)) begin
        state_d = ARMED;
      end
      // Non-overlapping mode discards the bits that formed this match.
      if (y && (OVERLAP == 0)) begin
        fill_d  = '0;
        state_d = FILL;
      end
    end
    armed_d = (fill_d >= FILL_MAX);
  end

  // Detector state registers with registered armed flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign armed = armed_q;

`ifdef SEQ_DETECT_CNT_EN
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_sat_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (y),
    .count   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect.sv
// Bench for seq_detect: three instances (overlap, non-overlap, 2-bit/2-bit counter).
module tb_seq_detect;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [2:0] ld, en, xb;
  logic [3:0] patA, patB;
  logic [1:0] patC;
  logic       yA, yB, yC;
  logic       armA, armB, armC;
  logic [7:0] mcA, mcB;
  logic [1:0] mcC;

  seq_detect #(.PAT_W(4), .CNT_W(8), .OVERLAP(1)) dutA (
    .clk(clk), .reset_n(reset_n), .load(ld[0]), .pattern_in(patA),
    .en(en[0]), .x(xb[0]), .y(yA), .armed(armA), .match_cnt(mcA));

  seq_detect #(.PAT_W(4), .CNT_W(8), .OVERLAP(0)) dutB (
    .clk(clk), .reset_n(reset_n), .load(ld[1]), .pattern_in(patB),
    .en(en[1]), .x(xb[1]), .y(yB), .armed(armB), .match_cnt(mcB));

  seq_detect #(.PAT_W(2), .CNT_W(2), .OVERLAP(1)) dutC (
    .clk(clk), .reset_n(reset_n), .load(ld[2]), .pattern_in(patC),
    .en(en[2]), .x(xb[2]), .y(yC), .armed(armC), .match_cnt(mcC));

  typedef struct {
    int         sel;
    logic       y;
    logic       armed;
    logic [7:0] cnt;
    int         tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   tag_n = 0;

  // Expected outputs observed mid-cycle: y for the current inputs,
  // armed/match_cnt as registered before this cycle's edge.
  task automatic push(input int sel, input bit ey, input bit ea, input int ec);
    exp_t e;
    e.sel   = sel;
    e.y     = ey;
    e.armed = ea;
    e.cnt   = CNT_ON ? 8'(ec) : 8'd0;
    e.tag   = tag_n;
    tag_n++;
    q.push_back(e);
  endtask

  task automatic step(input int sel, input bit l, input logic [3:0] p,
                      input bit e, input bit xv,
                      input bit ey, input bit ea, input int ec);
    @(posedge clk);
    #1;
    ld = '0; en = '0; xb = '0;
    ld[sel] = l; en[sel] = e; xb[sel] = xv;
    case (sel)
      0:       patA = p;
      1:       patB = p;
      default: patC = p[1:0];
    endcase
    push(sel, ey, ea, ec);
  endtask

  // Monitor: pop one expectation per cycle and compare with the selected DUT.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      logic       ay, aa;
      logic [7:0] ac;
      mon_e = q.pop_front();
      case (mon_e.sel)
        0:       begin ay = yA; aa = armA; ac = mcA; end
        1:       begin ay = yB; aa = armB; ac = mcB; end
        default: begin ay = yC; aa = armC; ac = {6'd0, mcC}; end
      endcase
      total++;
      if (ay !== mon_e.y) begin
        bad++;
        $display("FAIL y step=%0d dut=%0d got=%b want=%b", mon_e.tag, mon_e.sel, ay, mon_e.y);
      end
      total++;
      if (aa !== mon_e.armed) begin
        bad++;
        $display("FAIL armed step=%0d dut=%0d got=%b want=%b", mon_e.tag, mon_e.sel, aa, mon_e.armed);
      end
      total++;
      if (ac !== mon_e.cnt) begin
        bad++;
        $display("FAIL match_cnt step=%0d dut=%0d got=%0d want=%0d", mon_e.tag, mon_e.sel, ac, mon_e.cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    ld = '0; en = '0; xb = '0;
    patA = '0; patB = '0; patC = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state and IDLE ignores bits
    step(0, 0, 4'h0, 0, 0,  0, 0, 0);
    step(0, 0, 4'h0, 1, 1,  0, 0, 0);

    // overlapping detection of 1011 in 1,0,1,1,0,1,1
    step(0, 1, 4'b1011, 0, 0,  0, 0, 0);
    step(0, 0, 4'h0, 1, 1,  0, 0, 0);
    step(0, 0, 4'h0, 1, 0,  0, 0, 0);
    step(0, 0, 4'h0, 1, 1,  0, 0, 0);
    step(0, 0, 4'h0, 1, 1,  1, 0, 0);
    step(0, 0, 4'h0, 1, 0,  0, 1, 1);
    step(0, 0, 4'h0, 1, 1,  0, 1, 1);
    step(0, 0, 4'h0, 1, 1,  1, 1, 1);
    step(0, 0, 4'h0, 0, 1,  0, 1, 2);

    // non-overlapping: match on bit 4 only, armed stays low
    step(1, 1, 4'b1011, 0, 0,  0, 0, 0);
    step(1, 0, 4'h0, 1, 1,  0, 0, 0);
    step(1, 0, 4'h0, 1, 0,  0, 0, 0);
    step(1, 0, 4'h0, 1, 1,  0, 0, 0);
    step(1, 0, 4'h0, 1, 1,  1, 0, 0);
    step(1, 0, 4'h0, 1, 0,  0, 0, 1);
    step(1, 0, 4'h0, 1, 1,  0, 0, 1);
    step(1, 0, 4'h0, 1, 1,  0, 0, 1);
    step(1, 0, 4'h0, 0, 0,  0, 0, 1);

    // reload keeps count; en gaps between bits 2 and 3 and before bit 4
    step(0, 1, 4'b1011, 0, 0,  0, 1, 2);
    step(0, 0, 4'h0, 1, 1,  0, 0, 2);
    step(0, 0, 4'h0, 1, 0,  0, 0, 2);
    step(0, 0, 4'h0, 0, 1,  0, 0, 2);
    step(0, 0, 4'h0, 0, 1,  0, 0, 2);
    step(0, 0, 4'h0, 0, 1,  0, 0, 2);
    step(0, 0, 4'h0, 1, 1,  0, 0, 2);
    step(0, 0, 4'h0, 0, 1,  0, 0, 2);
    step(0, 0, 4'h0, 1, 1,  1, 0, 2);
    step(0, 0, 4'h0, 0, 0,  0, 1, 3);

    // load 0110 on a would-be 1011 match, then detect 0110 from FILL
    step(0, 0, 4'h0, 1, 0,  0, 1, 3);
    step(0, 0, 4'h0, 1, 1,  0, 1, 3);
    step(0, 1, 4'b0110, 1, 1,  0, 1, 3);
    step(0, 0, 4'h0, 0, 0,  0, 0, 3);
    step(0, 0, 4'h0, 1, 0,  0, 0, 3);
    step(0, 0, 4'h0, 1, 1,  0, 0, 3);
    step(0, 0, 4'h0, 1, 1,  0, 0, 3);
    step(0, 0, 4'h0, 1, 0,  1, 0, 3);
    step(0, 0, 4'h0, 0, 0,  0, 1, 4);

    // 2-bit counter saturates at 3 on six consecutive 1s with pattern 11
    step(2, 1, 4'b0011, 0, 0,  0, 0, 0);
    step(2, 0, 4'h0, 1, 1,  0, 0, 0);
    step(2, 0, 4'h0, 1, 1,  1, 0, 0);
    step(2, 0, 4'h0, 1, 1,  1, 1, 1);
    step(2, 0, 4'h0, 1, 1,  1, 1, 2);
    step(2, 0, 4'h0, 1, 1,  1, 1, 3);
    step(2, 0, 4'h0, 1, 1,  1, 1, 3);
    step(2, 0, 4'h0, 0, 0,  0, 1, 3);

    // asynchronous reset mid-stream, on a cycle that would have matched
    step(0, 1, 4'b1011, 0, 0,  0, 1, 4);
    step(0, 0, 4'h0, 1, 1,  0, 0, 4);
    step(0, 0, 4'h0, 1, 0,  0, 0, 4);
    step(0, 0, 4'h0, 1, 1,  0, 0, 4);
    @(posedge clk);
    #1;
    ld = '0; en = '0; xb = '0;
    en[0] = 1'b1; xb[0] = 1'b1;
    #1 reset_n = 1'b0;
    push(0, 0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // no new load: bits are ignored
    step(0, 0, 4'h0, 1, 1,  0, 0, 0);
    step(0, 0, 4'h0, 1, 0,  0, 0, 0);
    step(0, 0, 4'h0, 1, 1,  0, 0, 0);
    step(0, 0, 4'h0, 1, 1,  0, 0, 0);
    step(0, 0, 4'h0, 0, 0,  0, 0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
